// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receive framer states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity modes.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Link timing: 49.152 MHz system clock, 9600 baud.
    localparam int CLK_HZ        = 49_152_000;
    localparam int BAUD          = 9600;
    localparam int BIT_CLKS      = CLK_HZ / BAUD;
    localparam int HALF_BIT_CLKS = BIT_CLKS / 2;

    // Parity error from the running XOR of data bits and the received parity bit.
    // ones_odd is 1 when data plus parity carries an odd number of ones.
    function automatic logic par_err(input int mode, input logic ones_odd);
        if (mode == PAR_ODD)
            return ~ones_odd;
        else if (mode == PAR_EVEN)
            return ones_odd;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line plus a falling-edge detector.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronise rxd and keep one delayed copy; the idle line level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rxd;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rxd_s    = r_sync;
    assign rxd_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detection, mid-bit sampling on bps_tick,
// optional parity, stop check, and a valid/ready output register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 bps_tick,
    output logic                 bps_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic w_rxd_s;
    logic w_rxd_fall;

    rx_state_t            r_state;
    logic [2:0]           r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr_pend;
    logic                 r_bps_en;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_perr;
    logic                 r_frame_err;
    logic                 r_overrun;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rxd_s    (w_rxd_s),
        .rxd_fall (w_rxd_fall)
    );

    // Frame state machine with the output register and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_perr_pend <= 1'b0;
            r_bps_en    <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_perr   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer took the byte; a delivery below may refill it this cycle.
            if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Ticks are ignored here; only a fresh falling edge arms a frame.
                    if (w_rxd_fall) begin
                        r_state  <= START;
                        r_bps_en <= 1'b1;
                    end
                end

                START: begin
                    if (bps_tick) begin
                        if (w_rxd_s) begin
                            // Start bit gone high at its centre: treat as a glitch.
                            r_state  <= IDLE;
                            r_bps_en <= 1'b0;
                        end else begin
                            r_state     <= DATA;
                            r_cnt       <= 3'd0;
                            r_par       <= 1'b0;
                            r_perr_pend <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (bps_tick) begin
                        r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_rxd_s;
                        r_cnt   <= r_cnt + 3'd1;
                        if (r_cnt == LAST_BIT)
                            r_state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end
                end

                uart_pkg::PARITY: begin
                    if (bps_tick) begin
                        r_perr_pend <= par_err(PARITY, r_par ^ w_rxd_s);
                        r_state     <= STOP;
                    end
                end

                STOP: begin
                    if (bps_tick) begin
                        r_state  <= IDLE;
                        r_bps_en <= 1'b0;
                        if (!w_rxd_s) begin
                            r_frame_err <= 1'b1;
                        end else if (!r_rx_valid || rx_ready) begin
                            r_rx_data  <= r_shift;
                            r_rx_perr  <= r_perr_pend;
                            r_rx_valid <= 1'b1;
                        end else begin
                            // Unread byte still held: keep it and drop the new one.
                            r_overrun <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_bps_en <= 1'b0;
                end
            endcase
        end
    end

    assign bps_en    = r_bps_en;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_perr   = r_rx_perr;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance and an 8E1 instance, each fed by a
// baud-generator model, with scoreboard monitors on the output handshakes.
module tb_uart_rx_frame;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic       rxd0 = 1'b1, tick0 = 1'b0, rdy0 = 1'b0;
    logic       en0, val0, perr0, fe0, ov0;
    logic [7:0] data0;
    logic       rxd2 = 1'b1, tick2 = 1'b0, rdy2 = 1'b0;
    logic       en2, val2, perr2, fe2, ov2;
    logic [7:0] data2;

    int total = 0;
    int bad   = 0;

    int half_c = HALF_BIT_CLKS;
    int bit_c  = BIT_CLKS;

    exp_t q0[$];
    exp_t q2[$];
    exp_t e0, e2;
    int   vc0 = 0, fc0 = 0, oc0 = 0, vc2 = 0, fc2 = 0, oc2 = 0;
    logic seen0 = 1'b0;
    int   cnt0 = 0, cnt2 = 0, tno0 = 0, tno2 = 0;

    uart_rx_frame #(.DATA_BITS(8), .PARITY(PAR_NONE)) dut0 (
        .clk(clk), .reset(reset), .rxd(rxd0), .bps_tick(tick0), .bps_en(en0),
        .rx_data(data0), .rx_valid(val0), .rx_ready(rdy0), .rx_perr(perr0),
        .frame_err(fe0), .overrun(ov0)
    );

    uart_rx_frame #(.DATA_BITS(8), .PARITY(PAR_EVEN)) dut2 (
        .clk(clk), .reset(reset), .rxd(rxd2), .bps_tick(tick2), .bps_en(en2),
        .rx_data(data2), .rx_valid(val2), .rx_ready(rdy2), .rx_perr(perr2),
        .frame_err(fe2), .overrun(ov2)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p);
        exp_t t;
        t.d = d;
        t.p = p;
        return t;
    endfunction

    // Baud generator models: counter held at 0 while bps_en is low, first tick
    // half_c clocks after bps_en rises, then every bit_c clocks.
    always begin
        @(negedge clk);
        if (!en0) begin
            cnt0 = 0; tick0 = 1'b0; tno0 = 0;
        end else begin
            cnt0++;
            tick0 = (cnt0 >= half_c) && (((cnt0 - half_c) % bit_c) == 0);
            if (tick0) tno0++;
        end
    end

    always begin
        @(negedge clk);
        if (!en2) begin
            cnt2 = 0; tick2 = 1'b0; tno2 = 0;
        end else begin
            cnt2++;
            tick2 = (cnt2 >= half_c) && (((cnt2 - half_c) % bit_c) == 0);
            if (tick2) tno2++;
        end
    end

    // Monitor for the 8N1 instance.
    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            if (val0) vc0++;
            if (fe0)  fc0++;
            if (ov0)  oc0++;
            if (en0)  seen0 = 1'b1;
            if (val0 && rdy0) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte0: got 0x%0h, want none", data0);
                end else begin
                    e0 = q0.pop_front();
                    check("data0", 32'(data0), 32'(e0.d));
                    check("perr0", 32'(perr0), 32'(e0.p));
                end
            end
        end
    end

    // Monitor for the 8E1 instance.
    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            if (val2) vc2++;
            if (fe2)  fc2++;
            if (ov2)  oc2++;
            if (val2 && rdy2) begin
                if (q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte2: got 0x%0h, want none", data2);
                end else begin
                    e2 = q2.pop_front();
                    check("data2", 32'(data2), 32'(e2.d));
                    check("perr2", 32'(perr2), 32'(e2.p));
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd0 = v;
        else          rxd2 = v;
        repeat (bit_c) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic send(input int sel, input logic [7:0] b, input logic haspar,
                        input logic pb, input logic sb);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, b[i]);
        if (haspar) drive(sel, pb);
        drive(sel, sb);
    endtask

    task automatic settle();
        @(negedge clk);
        #4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_en0",   32'(en0),   0);
        check("rst_val0",  32'(val0),  0);
        check("rst_data0", 32'(data0), 0);
        check("rst_perr0", 32'(perr0), 0);
        check("rst_fe0",   32'(fe0),   0);
        check("rst_ov0",   32'(ov0),   0);
        check("rst_en2",   32'(en2),   0);
        check("rst_val2",  32'(val2),  0);
        check("rst_data2", 32'(data2), 0);
        @(negedge clk);
        reset = 1'b0;
        rdy0  = 1'b1;
        rdy2  = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0x55 at full link timing
        q0.push_back(mk(8'h55, 1'b0));
        send(0, 8'h55, 1'b0, 1'b0, 1'b1);
        settle();
        check("t1_valid_cycles", 32'(vc0), 1);
        check("t1_bps_en_low",   32'(en0), 0);
        check("t1_frame_err",    32'(fc0), 0);
        check("t1_pending",      32'(q0.size()), 0);

        // Low glitch of 1000 clocks on the idle line
        seen0 = 1'b0;
        rxd0  = 1'b0;
        repeat (1000) @(negedge clk);
        rxd0 = 1'b1;
        repeat (2000) @(negedge clk);
        #4;
        check("glitch_bps_seen", 32'(seen0), 1);
        check("glitch_bps_low",  32'(en0),   0);
        check("glitch_valid",    32'(vc0),   1);
        check("glitch_fe",       32'(fc0),   0);
        check("glitch_ov",       32'(oc0),   0);

        // Shorter bit time from here on; the framer only follows the ticks
        half_c = 40;
        bit_c  = 80;
        repeat (5) @(negedge clk);

        // Even parity: 0xA3 has four ones, so parity bit 0 is correct
        q2.push_back(mk(8'hA3, 1'b0));
        send(2, 8'hA3, 1'b1, 1'b0, 1'b1);
        q2.push_back(mk(8'hA3, 1'b1));
        send(2, 8'hA3, 1'b1, 1'b1, 1'b1);
        settle();
        check("par_pending", 32'(q2.size()), 0);
        check("par_valid",   32'(vc2), 2);
        check("par_fe",      32'(fc2), 0);

        // Stop bit 0 then a break held low
        send(0, 8'h7E, 1'b0, 1'b0, 1'b0);
        settle();
        check("ferr_pulse", 32'(fc0), 1);
        check("ferr_valid", 32'(vc0), 1);
        seen0 = 1'b0;
        repeat (20000) @(negedge clk);
        #4;
        check("break_no_arm", 32'(seen0), 0);
        check("break_fe",     32'(fc0),   1);
        @(negedge clk);
        rxd0 = 1'b1;
        repeat (100) @(negedge clk);
        q0.push_back(mk(8'h81, 1'b0));
        send(0, 8'h81, 1'b0, 1'b0, 1'b1);
        settle();
        check("after_break_pending", 32'(q0.size()), 0);
        check("after_break_valid",   32'(vc0), 2);

        // Overrun with rx_ready low
        rdy0 = 1'b0;
        q0.push_back(mk(8'h12, 1'b0));
        send(0, 8'h12, 1'b0, 1'b0, 1'b1);
        send(0, 8'h34, 1'b0, 1'b0, 1'b1);
        settle();
        check("ovr_data",  32'(data0), 32'h12);
        check("ovr_valid", 32'(val0),  1);
        check("ovr_pulse", 32'(oc0),   1);

        // rx_ready raised in the very cycle the third frame's stop tick lands
        q0.push_back(mk(8'h56, 1'b0));
        fork
            send(0, 8'h56, 1'b0, 1'b0, 1'b1);
            begin
                found = 1'b0;
                for (int i = 0; i < 20 * bit_c && !found; i++) begin
                    @(negedge clk);
                    #1;
                    if (tick0 && tno0 == 10) begin
                        rdy0  = 1'b1;
                        found = 1'b1;
                    end
                end
                if (!found) begin
                    total++;
                    bad++;
                    $display("FAIL stop_tick_wait: got timeout, want stop tick");
                end else begin
                    @(negedge clk);
                    #4;
                    check("same_cycle_valid", 32'(val0),  1);
                    check("same_cycle_data",  32'(data0), 32'h56);
                end
            end
        join
        settle();
        check("same_cycle_ov",      32'(oc0), 1);
        check("same_cycle_pending", 32'(q0.size()), 0);
        check("same_cycle_drained", 32'(val0), 0);

        // Reset during data bit 4, held until the interrupted frame is over
        fork
            send(0, 8'hF0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (5 * bit_c + 60) @(negedge clk);
                #1;
                check("mid_bps_en", 32'(en0), 1);
                reset = 1'b1;
                #1;
                check("mid_rst_en",   32'(en0),   0);
                check("mid_rst_val",  32'(val0),  0);
                check("mid_rst_data", 32'(data0), 0);
                check("mid_rst_perr", 32'(perr0), 0);
                check("mid_rst_fe",   32'(fe0),   0);
                check("mid_rst_ov",   32'(ov0),   0);
            end
        join
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        #4;
        check("post_rst_idle", 32'(en0), 0);
        q0.push_back(mk(8'hC3, 1'b0));
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        settle();
        check("post_rst_pending", 32'(q0.size()), 0);
        check("post_rst_fe",      32'(fc0), 1);
        check("post_rst_ov",      32'(oc0), 1);
        check("dut2_ov",          32'(oc2), 0);
        check("dut2_pending",     32'(q2.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
